// File: rtl/led_share_sched.sv
// Round-robin owner scheduler for a shared 8-bit LED bank.
// Four requesters get time slots and may show their patterns steady or blinking.
module led_share_sched #(
  parameter int unsigned TICK_CYCLES = 2_500_000,
  parameter int unsigned SLOT_TICKS  = 10,
  parameter int unsigned BLINK_TICKS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] pattern,
  input  logic [3:0]  blink_en,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic [7:0]  leds
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);
  localparam int unsigned SW = $clog2(SLOT_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] slot_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    last;
  logic          phase;

  logic          tick;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    cand;
  logic          others;
  logic [7:0]    own_pat;

  assign tick    = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign others  = |(req & ~gnt);
  assign own_pat = pattern[{last, 3'b000} +: 8];
  assign busy    = |gnt;

  // While OWN, last always holds the current owner's index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      leds      <= '0;
      tick_cnt  <= '0;
      slot_cnt  <= '0;
      blink_cnt <= '0;
      last      <= 2'd3;
      phase     <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      leds     <= (state == OWN && (!blink_en[last] || phase)) ? own_pat : '0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= OWN;
            gnt       <= 4'b0001 << win;
            last      <= win;
            slot_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
          end
        end
        OWN: begin
          if (!req[last]) begin
            state <= IDLE;
            gnt   <= '0;
          end else if (tick) begin
            if (slot_cnt == SW'(SLOT_TICKS - 1)) begin
              if (others) begin
                state <= IDLE;
                gnt   <= '0;
              end else begin
                slot_cnt <= '0;
              end
            end else begin
              slot_cnt <= slot_cnt + SW'(1);
            end
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
              phase     <= ~phase;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_share_sched.sv
// Randomized and directed checks of led_share_sched against a behavioural owner/slot model.
module tb_led_share_sched;

  localparam int TC = 4;
  localparam int ST = 3;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  blink_en;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  leds;

  int errs   = 0;
  int checks = 0;

  // model state: owner = -1 when nobody holds the bank
  int   m_owner, m_last, m_slot, m_blink, m_tcnt;
  bit   m_phase;
  logic [7:0] m_leds;

  led_share_sched #(.TICK_CYCLES(TC), .SLOT_TICKS(ST), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .pattern(pattern), .blink_en(blink_en),
    .gnt(gnt), .busy(busy), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_step();
    bit tick;
    logic [7:0] nl;
    if (rst) begin
      m_owner = -1; m_last = 3; m_slot = 0; m_blink = 0; m_phase = 1;
      m_leds = 8'h00; m_tcnt = 0;
      return;
    end
    tick   = (m_tcnt == TC - 1);
    m_tcnt = (m_tcnt + 1) % TC;
    nl = (m_owner >= 0 && (!blink_en[m_owner] || m_phase)) ? pattern[m_owner*8 +: 8] : 8'h00;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (req[c]) begin
          m_owner = c; m_last = c; m_slot = 0; m_blink = 0; m_phase = 1;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (tick) begin
      bit contender;
      contender = (req & ~m_gnt()) != 4'b0000;
      if (m_blink == BT - 1) begin
        m_phase = !m_phase; m_blink = 0;
      end else begin
        m_blink++;
      end
      if (m_slot == ST - 1) begin
        if (contender) m_owner = -1;
        else m_slot = 0;
      end else begin
        m_slot++;
      end
    end
    m_leds = nl;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_val("gnt", 32'(gnt), 32'(m_gnt()));
    check_val("busy", 32'(busy), 32'(m_owner >= 0));
    check_val("leds", 32'(leds), 32'(m_leds));
    check_val("onehot", 32'($onehot0(gnt)), 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; pattern = 32'h0; blink_en = 4'h0;
    @(negedge clk);
    // reset held with all requests pending
    run(3);
    check_val("rst_gnt", 32'(gnt), 32'h0);
    check_val("rst_leds", 32'(leds), 32'h0);
    rst = 1'b0;
    step();
    check_val("first_gnt", 32'(gnt), 32'h1);

    // single steady owner keeps the bank across slot expiries
    rst = 1'b1; req = 4'b0010; pattern = 32'h0000_A500; blink_en = 4'h0;
    step();
    rst = 1'b0;
    run(2);
    check_val("own1_gnt", 32'(gnt), 32'h2);
    check_val("own1_leds", 32'(leds), 32'hA5);
    run(40);
    check_val("own1_hold", 32'(gnt), 32'h2);

    // two requesters alternate with a gap
    req = 4'b0101; pattern = 32'h0033_0011;
    run(60);

    // blinking owner
    rst = 1'b1; req = 4'b0100; pattern = 32'h00FF_0000; blink_en = 4'b0100;
    step();
    rst = 1'b0;
    run(60);

    // owner drop with another requester waiting
    rst = 1'b1; req = 4'b1001; pattern = 32'h7E00_0042; blink_en = 4'h0;
    step();
    rst = 1'b0;
    run(3);
    check_val("drop_pre", 32'(gnt), 32'h1);
    req = 4'b1000;
    step();
    check_val("drop_gap", 32'(gnt), 32'h0);
    step();
    check_val("drop_new", 32'(gnt), 32'h8);
    check_val("drop_leds0", 32'(leds), 32'h0);
    step();
    check_val("drop_leds3", 32'(leds), 32'h7E);

    // reset during blink-off phase of an owner
    blink_en = 4'b1000;
    run(13);
    rst = 1'b1; req = 4'b1001;
    step();
    check_val("midrst_gnt", 32'(gnt), 32'h0);
    check_val("midrst_leds", 32'(leds), 32'h0);
    rst = 1'b0;
    step();
    check_val("midrst_win", 32'(gnt), 32'h1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) pattern = $urandom;
      if ($urandom_range(0, 63) == 0) blink_en = 4'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
